tx_serial_7e1_uc: RTL



---
 rtl/tx_serial_pkg.sv | 18 +
 rtl/tx_serial_7e1_uc_gerador_tick.sv | 36 +++
 rtl/tx_serial_7e1_uc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/tx_serial_pkg.sv
// Shared definitions for the 7E1 serial transmitter.
//   estado_t        : 4-bit FSM state codes (also shown on db_estado)
//   BAUD_DIV_PADRAO : default clock cycles per bit (50 MHz / 115200)
//   BITS_QUADRO     : shifts per frame (start, 7 data, parity, stop, idle)
package tx_serial_pkg;

  localparam int BAUD_DIV_PADRAO = 434;
  localparam int BITS_QUADRO     = 11;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARACAO  = 4'd1,
    ESPERA      = 4'd2,
    TRANSMISSAO = 4'd3,
    FINAL_TX    = 4'd4
  } estado_t;

endpackage

// File: rtl/tx_serial_7e1_uc_gerador_tick.sv
// Baud-tick generator for the transmitter control unit.
//   clock : system clock (rising edge)
//   reset : asynchronous reset, active-low
//   zera  : hold the counter at 0 (has priority over conta)
//   conta : advance the counter, wrapping from BAUD_DIV-1 to 0
//   tick  : high while the counter sits at BAUD_DIV-1 (combinational)
module gerador_tick
  import tx_serial_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic tick
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] ULTIMO = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= (cnt == ULTIMO) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == ULTIMO);

endmodule

// File: rtl/tx_serial_7e1_uc.sv
// Control unit for the 7E1 asynchronous serial transmitter. Sequences the
// datapath through one frame per start condition and reports completion.
//   clock     : system clock (rising edge)
//   reset     : asynchronous reset, active-low
//   partida   : transmit request
//   fim       : datapath modulo-12 counter at its last count
//   zera      : clear datapath counter
//   carrega   : load datapath shift register
//   conta     : increment datapath counter
//   desloca   : shift datapath shift register
//   ocupado   : frame in progress
//   pronto    : one-cycle frame-completion pulse
//   db_estado : current state code for debug display
// Build option TX_SERIAL_PARTIDA_EDGE_EN: when defined, a frame starts on the
// rising edge of partida instead of its level.
module tx_serial_7e1_uc
  import tx_serial_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic       fim,
  output logic       zera,
  output logic       carrega,
  output logic       conta,
  output logic       desloca,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  estado_t estado;
  estado_t prox;
  logic    inicio;
  logic    tick;
  logic    tick_zera;
  logic    tick_conta;

`ifdef TX_SERIAL_PARTIDA_EDGE_EN
  // Resets to 1 so a request already high when reset releases is not an edge.
  logic partida_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      partida_d <= 1'b1;
    end else begin
      partida_d <= partida;
    end
  end

  assign inicio = partida & ~partida_d;
`else
  assign inicio = partida;
`endif

  // Bit timing runs only while a frame is on the line, so every frame starts
  // with a full bit period after preparacao.
  assign tick_conta = (estado == ESPERA) || (estado == TRANSMISSAO);
  assign tick_zera  = ~tick_conta;

  gerador_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_gerador_tick (
    .clock(clock),
    .reset(reset),
    .zera (tick_zera),
    .conta(tick_conta),
    .tick (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= prox;
    end
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:     if (inicio) prox = PREPARACAO;
      PREPARACAO:  prox = ESPERA;
      ESPERA:      if (tick) prox = fim ? FINAL_TX : TRANSMISSAO;
      TRANSMISSAO: prox = ESPERA;
      FINAL_TX:    prox = INICIAL;
      default:     prox = INICIAL;
    endcase
  end

  always_comb begin
    zera    = 1'b0;
    carrega = 1'b0;
    conta   = 1'b0;
    desloca = 1'b0;
    ocupado = 1'b0;
    pronto  = 1'b0;
    case (estado)
      PREPARACAO: begin
        zera    = 1'b1;
        carrega = 1'b1;
        ocupado = 1'b1;
      end
      ESPERA: begin
        ocupado = 1'b1;
      end
      TRANSMISSAO: begin
        conta   = 1'b1;
        desloca = 1'b1;
        ocupado = 1'b1;
      end
      FINAL_TX: begin
        pronto = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule
